change_dispatcher: RTL and testbench

CHANGE_DISPATCHER -- requirements
Module: change_dispatcher

---
 rtl/change_dispatcher.sv | 169 ++++++++++++++++
 tb/tb_change_dispatcher.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispatcher.sv
// Change dispatcher: round-robin grant between two panels, greedy payout of
// 50/10/5/1 coins from a finite inventory through a valid/ready hopper port.
module change_dispatcher #(
    parameter logic [7:0] COIN50_INIT = 8'd10,
    parameter logic [7:0] COIN10_INIT = 8'd20,
    parameter logic [7:0] COIN5_INIT  = 8'd20,
    parameter logic [7:0] COIN1_INIT  = 8'd20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] amt0,
    input  logic [7:0] amt1,
    input  logic       refill,
    input  logic       coin_ready,
    output logic [1:0] gnt,
    output logic       owner,
    output logic       busy,
    output logic       coin_valid,
    output logic [7:0] coin_val,
    output logic       done,
    output logic       short,
    output logic [7:0] short_amt
);

    typedef enum logic [1:0] {IDLE, SELECT, PAY, FINISH} state_t;

    state_t     r_state;
    logic [7:0] r_inv [4];
    logic [7:0] r_remaining;
    logic [1:0] r_coin_idx;
    logic       r_last;
    logic [1:0] r_gnt;
    logic       r_owner;
    logic       r_busy;
    logic       r_coin_valid;
    logic [7:0] r_coin_val;
    logic       r_done;
    logic       r_short;
    logic [7:0] r_short_amt;

    logic       w_win;
    logic [7:0] w_amt;
    logic [7:0] w_rem_after;
    logic       w_has_coin;
    logic [1:0] w_idx;

    // Inventory slot 0 holds the largest coin, slot 3 the smallest.
    function automatic logic [7:0] denom(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'd50;
            2'd1:    return 8'd10;
            2'd2:    return 8'd5;
            default: return 8'd1;
        endcase
    endfunction

    function automatic logic [7:0] init_val(input logic [1:0] idx);
        case (idx)
            2'd0:    return COIN50_INIT;
            2'd1:    return COIN10_INIT;
            2'd2:    return COIN5_INIT;
            default: return COIN1_INIT;
        endcase
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_has_coin  = 1'b0;
        w_idx       = 2'd0;
        w_win       = (req0 && req1) ? ~r_last : req1;
        w_amt       = w_win ? amt1 : amt0;
        w_rem_after = r_remaining - r_coin_val;
        // Scan smallest to largest so the largest eligible coin is the last writer.
        for (int i = 3; i >= 0; i--) begin
            if (denom(2'(i)) <= r_remaining && r_inv[i] != 8'd0) begin
                w_has_coin = 1'b1;
                w_idx      = 2'(i);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_remaining  <= 8'd0;
            r_coin_idx   <= 2'd0;
            r_last       <= 1'b1;
            r_gnt        <= 2'b00;
            r_owner      <= 1'b0;
            r_busy       <= 1'b0;
            r_coin_valid <= 1'b0;
            r_coin_val   <= 8'd0;
            r_done       <= 1'b0;
            r_short      <= 1'b0;
            r_short_amt  <= 8'd0;
            // NOTE: the inventory is only four counters, so reset loads them directly like any other register.
            for (int i = 0; i < 4; i++) r_inv[i] <= init_val(2'(i));
        end else begin
            r_gnt  <= 2'b00;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (refill) begin
                        for (int i = 0; i < 4; i++) r_inv[i] <= init_val(2'(i));
                    end
                    if (req0 || req1) begin
                        r_gnt       <= w_win ? 2'b10 : 2'b01;
                        r_owner     <= w_win;
                        r_last      <= w_win;
                        r_remaining <= w_amt;
                        r_short     <= 1'b0;
                        r_short_amt <= 8'd0;
                        r_busy      <= 1'b1;
                        if (w_amt != 8'd0) begin
                            r_state <= SELECT;
                        end else begin
                            r_state <= FINISH;
                            r_done  <= 1'b1;
                        end
                    end
                end
                SELECT: begin
                    if (w_has_coin) begin
                        r_coin_val   <= denom(w_idx);
                        r_coin_idx   <= w_idx;
                        r_coin_valid <= 1'b1;
                        r_state      <= PAY;
                    end else begin
                        r_short     <= 1'b1;
                        r_short_amt <= r_remaining;
                        r_done      <= 1'b1;
                        r_state     <= FINISH;
                    end
                end
                PAY: begin
                    if (coin_ready) begin
                        r_remaining  <= w_rem_after;
                        r_coin_valid <= 1'b0;
                        if (r_inv[r_coin_idx] != 8'd0) r_inv[r_coin_idx] <= r_inv[r_coin_idx] - 8'd1;
                        if (w_rem_after != 8'd0) begin
                            r_state <= SELECT;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign owner      = r_owner;
    assign busy       = r_busy;
    assign coin_valid = r_coin_valid;
    assign coin_val   = r_coin_val;
    assign done       = r_done;
    assign short      = r_short;
    assign short_amt  = r_short_amt;

endmodule

// File: tb/tb_change_dispatcher.sv
// Self-checking bench for change_dispatcher: directed scenarios plus randomized
// requests checked against a greedy-payout inventory model.
module tb_change_dispatcher;

    logic       clk, reset;
    logic       req0, req1, refill, coin_ready;
    logic [7:0] amt0, amt1;
    logic [1:0] gnt;
    logic       owner, busy, coin_valid, done, short;
    logic [7:0] coin_val, short_amt;

    logic       s_req0, s_req1, s_refill, s_coin_ready;
    logic [7:0] s_amt0, s_amt1;
    logic [1:0] s_gnt;
    logic       s_owner, s_busy, s_coin_valid, s_done, s_short;
    logic [7:0] s_coin_val, s_short_amt;

    int checks = 0;
    int errors = 0;

    change_dispatcher dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .amt0(amt0), .amt1(amt1),
        .refill(refill), .coin_ready(coin_ready), .gnt(gnt), .owner(owner), .busy(busy),
        .coin_valid(coin_valid), .coin_val(coin_val), .done(done), .short(short),
        .short_amt(short_amt)
    );

    change_dispatcher #(.COIN5_INIT(8'd0), .COIN1_INIT(8'd2)) dut_s (
        .clk(clk), .reset(reset), .req0(s_req0), .req1(s_req1), .amt0(s_amt0), .amt1(s_amt1),
        .refill(s_refill), .coin_ready(s_coin_ready), .gnt(s_gnt), .owner(s_owner), .busy(s_busy),
        .coin_valid(s_coin_valid), .coin_val(s_coin_val), .done(s_done), .short(s_short),
        .short_amt(s_short_amt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    localparam int DEN [4] = '{50, 10, 5, 1};
    localparam int INIT [4] = '{10, 20, 20, 20};
    int m_inv [4];
    int m_last;
    int exp_coins[$];
    bit exp_short;
    int exp_short_amt;

    function automatic void model_reset_inv();
        for (int k = 0; k < 4; k++) m_inv[k] = INIT[k];
    endfunction

    function automatic int model_winner(input bit r0, input bit r1);
        int w;
        w = (r0 && r1) ? 1 - m_last : (r1 ? 1 : 0);
        m_last = w;
        return w;
    endfunction

    // Greedy payout: largest available coin not exceeding what is still owed.
    function automatic void model_pay(input int amt);
        int  rem;
        bit  found;
        rem = amt;
        exp_coins.delete();
        exp_short = 1'b0;
        exp_short_amt = 0;
        while (rem > 0) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!found && DEN[k] <= rem && m_inv[k] > 0) begin
                    found = 1'b1;
                    exp_coins.push_back(DEN[k]);
                    rem -= DEN[k];
                    m_inv[k]--;
                end
            end
            if (!found) begin
                exp_short = 1'b1;
                exp_short_amt = rem;
                break;
            end
        end
    endfunction

    function automatic bit same_q(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string q2s(input int q[$]);
        string s;
        s = "{";
        foreach (q[i]) s = {s, $sformatf(" %0d", q[i])};
        return {s, " }"};
    endfunction

    // ---------------- observation of one payout on the main DUT ----------------
    int         obs_coins[$];
    logic [1:0] obs_gnt;
    logic       obs_owner, obs_short, obs_short_at_gnt;
    logic [7:0] obs_short_amt;
    bit         obs_done, obs_timeout, obs_unstable, obs_busy_bad, obs_gnt_stuck;
    int         obs_stall, obs_first_coin, obs_done_cyc;
    bit         pay_refill;

    task automatic observe(input int stall);
        int hold;
        bit in_offer;
        int cur;
        bit got;
        obs_coins.delete();
        obs_gnt = 2'b00; obs_owner = 1'b0; obs_short = 1'b0; obs_short_amt = 8'd0;
        obs_short_at_gnt = 1'b0; obs_done = 1'b0; obs_timeout = 1'b0; obs_unstable = 1'b0;
        obs_busy_bad = 1'b0; obs_gnt_stuck = 1'b0; obs_stall = 0; obs_first_coin = -1;
        obs_done_cyc = -1;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (gnt != 2'b00) got = 1'b1;
        end
        if (!got) begin
            obs_timeout = 1'b1;
            return;
        end
        obs_gnt = gnt;
        obs_owner = owner;
        obs_short_at_gnt = short;
        if (gnt[0]) req0 = 1'b0;
        if (gnt[1]) req1 = 1'b0;
        refill = 1'b0;
        hold = 0;
        in_offer = 1'b0;
        cur = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc > 0 && gnt != 2'b00) obs_gnt_stuck = 1'b1;
            if (!busy) obs_busy_bad = 1'b1;
            if (done) begin
                obs_done = 1'b1;
                obs_done_cyc = cyc;
                obs_short = short;
                obs_short_amt = short_amt;
                if (coin_valid) obs_unstable = 1'b1;
                break;
            end
            if (coin_valid) begin
                if (!in_offer) begin
                    in_offer = 1'b1;
                    cur = int'(coin_val);
                    obs_coins.push_back(int'(coin_val));
                    hold = stall;
                    if (obs_first_coin < 0) obs_first_coin = cyc;
                end else if (int'(coin_val) != cur) begin
                    obs_unstable = 1'b1;
                end
                if (hold > 0) begin
                    coin_ready = 1'b0;
                    refill = pay_refill;
                    hold--;
                    obs_stall++;
                end else begin
                    coin_ready = 1'b1;
                    refill = 1'b0;
                    in_offer = 1'b0;
                end
            end else begin
                if (in_offer) obs_unstable = 1'b1;
                coin_ready = 1'b1;
                refill = 1'b0;
            end
        end
        if (!obs_done) obs_timeout = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; amt0 = 8'd0; amt1 = 8'd0; refill = 1'b0; coin_ready = 1'b1;
        s_req0 = 1'b0; s_req1 = 1'b0; s_amt0 = 8'd0; s_amt1 = 8'd0; s_refill = 1'b0;
        s_coin_ready = 1'b1;
        pay_refill = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset_inv();
        m_last = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; amt0 = 8'd0; amt1 = 8'd0; refill = 1'b0; coin_ready = 1'b1;
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b exp 00", gnt); end
        checks++; if (owner !== 1'b0) begin errors++; $display("FAIL reset_owner: got %b exp 0", owner); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (coin_valid !== 1'b0) begin errors++; $display("FAIL reset_coin_valid: got %b exp 0", coin_valid); end
        checks++; if (coin_val !== 8'd0) begin errors++; $display("FAIL reset_coin_val: got %0d exp 0", coin_val); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
        checks++; if (short !== 1'b0) begin errors++; $display("FAIL reset_short: got %b exp 0", short); end
        checks++; if (short_amt !== 8'd0) begin errors++; $display("FAIL reset_short_amt: got %0d exp 0", short_amt); end
        do_reset();
    endtask

    task automatic test_basic();
        int exp_q[$];
        do_reset();
        exp_q = '{10, 10, 10, 5};
        @(negedge clk);
        amt0 = 8'd35; req0 = 1'b1;
        observe(0);
        checks++; if (obs_timeout) begin errors++; $display("FAIL basic_timeout: got timeout exp done"); end
        checks++; if (obs_gnt !== 2'b01) begin errors++; $display("FAIL basic_gnt: got %b exp 01", obs_gnt); end
        checks++; if (obs_owner !== 1'b0) begin errors++; $display("FAIL basic_owner: got %b exp 0", obs_owner); end
        checks++; if (obs_first_coin != 1) begin errors++; $display("FAIL basic_latency: got %0d exp 1", obs_first_coin); end
        checks++; if (!same_q(obs_coins, exp_q)) begin errors++; $display("FAIL basic_coins: got %s exp %s", q2s(obs_coins), q2s(exp_q)); end
        checks++; if (obs_short !== 1'b0) begin errors++; $display("FAIL basic_short: got %b exp 0", obs_short); end
        checks++; if (obs_busy_bad || obs_gnt_stuck) begin errors++; $display("FAIL basic_busy_gnt: got busy_bad=%0d gnt_stuck=%0d exp 0 0", obs_busy_bad, obs_gnt_stuck); end
        checks++; if (dut.r_inv[1] !== 8'd17) begin errors++; $display("FAIL basic_inv10: got %0d exp 17", dut.r_inv[1]); end
        checks++; if (dut.r_inv[2] !== 8'd19) begin errors++; $display("FAIL basic_inv5: got %0d exp 19", dut.r_inv[2]); end
    endtask

    task automatic test_tie();
        int exp_a[$];
        int exp_b[$];
        do_reset();
        exp_a = '{10};
        exp_b = '{10, 5};
        @(negedge clk);
        amt0 = 8'd10; amt1 = 8'd15; req0 = 1'b1; req1 = 1'b1;
        observe(0);
        checks++; if (obs_gnt !== 2'b01) begin errors++; $display("FAIL tie_first_gnt: got %b exp 01", obs_gnt); end
        checks++; if (!same_q(obs_coins, exp_a)) begin errors++; $display("FAIL tie_first_coins: got %s exp %s", q2s(obs_coins), q2s(exp_a)); end
        observe(0);
        checks++; if (obs_gnt !== 2'b10) begin errors++; $display("FAIL tie_second_gnt: got %b exp 10", obs_gnt); end
        checks++; if (obs_owner !== 1'b1) begin errors++; $display("FAIL tie_second_owner: got %b exp 1", obs_owner); end
        checks++; if (!same_q(obs_coins, exp_b)) begin errors++; $display("FAIL tie_second_coins: got %s exp %s", q2s(obs_coins), q2s(exp_b)); end
    endtask

    task automatic test_stall();
        int exp_q[$];
        do_reset();
        exp_q = '{50};
        @(negedge clk);
        amt0 = 8'd50; req0 = 1'b1;
        observe(3);
        checks++; if (!same_q(obs_coins, exp_q)) begin errors++; $display("FAIL stall_coins: got %s exp %s", q2s(obs_coins), q2s(exp_q)); end
        checks++; if (obs_unstable) begin errors++; $display("FAIL stall_stable: got unstable offer exp stable"); end
        checks++; if (obs_stall != 3) begin errors++; $display("FAIL stall_cycles: got %0d exp 3", obs_stall); end
        checks++; if (!obs_done || obs_short !== 1'b0) begin errors++; $display("FAIL stall_done: got done=%0d short=%b exp 1 0", obs_done, obs_short); end
        checks++; if (dut.r_inv[0] !== 8'd9) begin errors++; $display("FAIL stall_inv50: got %0d exp 9", dut.r_inv[0]); end
    endtask

    task automatic test_zero();
        do_reset();
        @(negedge clk);
        amt1 = 8'd0; req1 = 1'b1;
        observe(0);
        checks++; if (obs_gnt !== 2'b10) begin errors++; $display("FAIL zero_gnt: got %b exp 10", obs_gnt); end
        checks++; if (obs_coins.size() != 0) begin errors++; $display("FAIL zero_coins: got %s exp { }", q2s(obs_coins)); end
        checks++; if (obs_done_cyc != 0 || obs_short !== 1'b0) begin errors++; $display("FAIL zero_done: got cyc=%0d short=%b exp 0 0", obs_done_cyc, obs_short); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_after: got done=%b busy=%b exp 0 0", done, busy); end
    endtask

    task automatic test_shortfall();
        int  coins[$];
        int  exp_q[$];
        logic [1:0] sg;
        bit  fin;
        logic sh, sh_at_gnt;
        logic [7:0] sha;
        do_reset();
        exp_q = '{1, 1};
        sg = 2'b00; fin = 1'b0; sh = 1'b0; sha = 8'd0; sh_at_gnt = 1'b1;
        @(negedge clk);
        s_amt0 = 8'd8; s_req0 = 1'b1;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            if (s_gnt != 2'b00) begin sg = s_gnt; s_req0 = 1'b0; end
            if (s_coin_valid) coins.push_back(int'(s_coin_val));
            if (s_done) begin fin = 1'b1; sh = s_short; sha = s_short_amt; end
        end
        checks++; if (sg !== 2'b01) begin errors++; $display("FAIL short_gnt: got %b exp 01", sg); end
        checks++; if (!same_q(coins, exp_q)) begin errors++; $display("FAIL short_coins: got %s exp %s", q2s(coins), q2s(exp_q)); end
        checks++; if (!fin || sh !== 1'b1 || sha !== 8'd6) begin errors++; $display("FAIL short_result: got done=%0d short=%b amt=%0d exp 1 1 6", fin, sh, sha); end
        checks++; if (dut_s.r_inv[3] !== 8'd0) begin errors++; $display("FAIL short_inv1: got %0d exp 0", dut_s.r_inv[3]); end
        coins.delete();
        fin = 1'b0;
        @(negedge clk);
        s_amt0 = 8'd3; s_req0 = 1'b1;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            if (s_gnt != 2'b00) begin sh_at_gnt = s_short; s_req0 = 1'b0; end
            if (s_coin_valid) coins.push_back(int'(s_coin_val));
            if (s_done) begin fin = 1'b1; sh = s_short; sha = s_short_amt; end
        end
        checks++; if (sh_at_gnt !== 1'b0) begin errors++; $display("FAIL short_clear_on_gnt: got %b exp 0", sh_at_gnt); end
        checks++; if (coins.size() != 0 || !fin || sh !== 1'b1 || sha !== 8'd3) begin errors++; $display("FAIL short_empty: got coins=%s short=%b amt=%0d exp { } 1 3", q2s(coins), sh, sha); end
    endtask

    task automatic test_reset_mid();
        int  nvalid;
        bit  got;
        int  exp_q[$];
        do_reset();
        exp_q = '{10, 10};
        @(negedge clk);
        amt0 = 8'd20; req0 = 1'b1;
        nvalid = 0; got = 1'b0;
        for (int c = 0; c < 60 && nvalid < 2; c++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin got = 1'b1; req0 = 1'b0; end
            if (coin_valid) nvalid++;
        end
        checks++; if (!got || nvalid != 2) begin errors++; $display("FAIL rmid_reach_second: got gnt=%0d coins=%0d exp 1 2", got, nvalid); end
        checks++; if (dut.r_inv[1] !== 8'd19) begin errors++; $display("FAIL rmid_inv_before: got %0d exp 19", dut.r_inv[1]); end
        reset = 1'b1;
        #1;
        checks++; if ({gnt, owner, busy, coin_valid, done, short} !== 7'd0 || coin_val !== 8'd0 || short_amt !== 8'd0)
        begin
            errors++;
            $display("FAIL rmid_outputs: got gnt=%b owner=%b busy=%b cv=%b val=%0d done=%b short=%b samt=%0d exp all 0",
                     gnt, owner, busy, coin_valid, coin_val, done, short, short_amt);
        end
        checks++; if (dut.r_inv[1] !== 8'd20) begin errors++; $display("FAIL rmid_inv_after: got %0d exp 20", dut.r_inv[1]); end
        @(negedge clk);
        reset = 1'b0;
        model_reset_inv();
        m_last = 1;
        amt0 = 8'd20; req0 = 1'b1;
        observe(0);
        checks++; if (obs_gnt !== 2'b01 || !same_q(obs_coins, exp_q)) begin errors++; $display("FAIL rmid_resume: got gnt=%b coins=%s exp 01 %s", obs_gnt, q2s(obs_coins), q2s(exp_q)); end
    endtask

    task automatic test_refill();
        int exp_q[$];
        do_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            amt0 = 8'd250; req0 = 1'b1;
            observe(0);
        end
        exp_q = '{10, 10, 10, 10, 10, 10};
        pay_refill = 1'b1;
        @(negedge clk);
        amt0 = 8'd60; req0 = 1'b1;
        observe(1);
        pay_refill = 1'b0;
        checks++; if (!same_q(obs_coins, exp_q)) begin errors++; $display("FAIL refill_ignored_busy: got %s exp %s", q2s(obs_coins), q2s(exp_q)); end
        exp_q = '{50, 50};
        @(negedge clk);
        amt0 = 8'd100; req0 = 1'b1; refill = 1'b1;
        observe(0);
        checks++; if (!same_q(obs_coins, exp_q)) begin errors++; $display("FAIL refill_with_req: got %s exp %s", q2s(obs_coins), q2s(exp_q)); end
    endtask

    task automatic test_random();
        bit r0, r1, p0, p1, rf;
        int a0, a1, w, mode, stall;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            mode = int'($urandom_range(0, 2));
            r0 = (mode != 1);
            r1 = (mode != 0);
            a0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 255));
            a1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 255));
            rf = ($urandom_range(0, 4) == 0);
            stall = int'($urandom_range(0, 2));
            @(negedge clk);
            amt0 = 8'(a0); amt1 = 8'(a1); req0 = r0; req1 = r1; refill = rf;
            if (rf) model_reset_inv();
            p0 = r0; p1 = r1;
            while (p0 || p1) begin
                w = model_winner(p0, p1);
                if (w == 1) p1 = 1'b0; else p0 = 1'b0;
                model_pay(w == 1 ? a1 : a0);
                observe(stall);
                checks++;
                if (obs_timeout || obs_gnt !== (w == 1 ? 2'b10 : 2'b01) || obs_owner !== w[0]) begin
                    errors++;
                    $display("FAIL rand_gnt it=%0d: got gnt=%b owner=%b timeout=%0d exp panel %0d", it, obs_gnt, obs_owner, obs_timeout, w);
                end
                checks++;
                if (!same_q(obs_coins, exp_coins) || obs_unstable) begin
                    errors++;
                    $display("FAIL rand_coins it=%0d: got %s unstable=%0d exp %s", it, q2s(obs_coins), obs_unstable, q2s(exp_coins));
                end
                checks++;
                if (obs_short !== exp_short || int'(obs_short_amt) != exp_short_amt || obs_short_at_gnt !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_short it=%0d: got short=%b amt=%0d at_gnt=%b exp %b %0d 0", it, obs_short, obs_short_amt, obs_short_at_gnt, exp_short, exp_short_amt);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_stall();
        test_zero();
        test_shortfall();
        test_reset_mid();
        test_refill();
        test_random();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
